bus_quantum_scheduler: RTL and testbench



---
 rtl/bus_quantum_scheduler.sv | 145 ++++++++++++++
 tb/tb_bus_quantum_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bus_quantum_scheduler.sv
// bus_quantum_scheduler: time-slice owner of the shared bus with safe-point handover windows
//
// Ports:
//   CLK            system clock
//   RST            asynchronous, active-high reset
//   i_init_done    scheduling frozen while low
//   i_req          per-core bus-wanted flags
//   i_idle         per-core safe-boundary flags (only the owner's bit gates a switch)
//   i_dram_busy    DRAM controller busy, blocks a switch
//   i_txn_active   owner has an open access, blocks a switch
//   o_grant_idx    current owner index
//   o_grant_oh     one-hot form of o_grant_idx
//   o_hold         bus busy to all cores during the handover window
//   o_switch       one-cycle pulse in the cycle the grant changes
//   o_state        FSM state (0 own, 1 hold, 2 switch, 3 settle)
//   o_sw_count     switch counter (BUS_SCHED_STATS_EN, else 0)
//   o_hold_cycles  cycles with o_hold high (BUS_SCHED_STATS_EN, else 0)
//
// Optional feature macro: BUS_SCHED_STATS_EN enables the two statistics counters.
module bus_quantum_scheduler #(
    parameter int NCORES  = 2,
    parameter int CW      = 1,
    parameter int QUANTUM = 16,
    parameter int GAP     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_init_done,
    input  logic [NCORES-1:0] i_req,
    input  logic [NCORES-1:0] i_idle,
    input  logic              i_dram_busy,
    input  logic              i_txn_active,
    output logic [CW-1:0]     o_grant_idx,
    output logic [NCORES-1:0] o_grant_oh,
    output logic              o_hold,
    output logic              o_switch,
    output logic [1:0]        o_state,
    output logic [31:0]       o_sw_count,
    output logic [31:0]       o_hold_cycles
);
    localparam logic [1:0]  S_OWN    = 2'd0;
    localparam logic [1:0]  S_HOLD   = 2'd1;
    localparam logic [1:0]  S_SWITCH = 2'd2;
    localparam logic [1:0]  S_SETTLE = 2'd3;
    localparam logic [15:0] Q_MAX    = 16'(QUANTUM - 1);
    localparam logic [7:0]  G_MAX    = 8'(GAP - 1);
    localparam logic [CW:0] N_WRAP   = (CW+1)'(NCORES);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_grant;
    logic [CW-1:0]       r_next;
    logic [15:0]         r_cnt;
    logic [7:0]          r_scnt;
    logic [2*NCORES-1:0] w_req_dbl;
    logic [NCORES-1:0]   w_req_rot;
    logic [CW:0]         w_off;
    logic [CW:0]         w_sum;
    logic [CW-1:0]       w_nxt;
    logic                w_has_nxt;
    logic                w_ready;

    // Rotate requests so bit k is core (grant+k) mod NCORES; bit 0 is the owner.
    assign w_req_dbl = {i_req, i_req};
    assign w_req_rot = NCORES'(w_req_dbl >> r_grant);

    // Smallest nonzero offset with a request wins, giving round-robin from grant+1.
    always_comb begin
        w_has_nxt = 1'b0;
        w_off     = '0;
        for (int k = NCORES - 1; k >= 1; k--) begin
            if (w_req_rot[k]) begin
                w_has_nxt = 1'b1;
                w_off     = (CW+1)'(k);
            end
        end
    end

    assign w_sum   = {1'b0, r_grant} + w_off;
    assign w_nxt   = (w_sum >= N_WRAP) ? CW'(w_sum - N_WRAP) : CW'(w_sum);
    assign w_ready = (r_cnt == Q_MAX || !w_req_rot[0]) && w_has_nxt && i_idle[r_grant]
                     && !i_dram_busy && !i_txn_active;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_OWN;
            r_grant <= '0;
            r_next  <= '0;
            r_cnt   <= '0;
            r_scnt  <= '0;
        end else if (i_init_done) begin
            case (r_state)
                S_OWN: begin
                    r_cnt <= (r_cnt == Q_MAX) ? r_cnt : r_cnt + 16'd1;
                    if (w_ready) begin
                        r_state <= S_HOLD;
                        r_next  <= w_nxt;
                    end
                end
                S_HOLD: begin
                    r_state <= S_SWITCH;
                    r_grant <= r_next;
                end
                S_SWITCH: begin
                    r_state <= S_SETTLE;
                    r_scnt  <= '0;
                end
                default: begin
                    r_scnt <= r_scnt + 8'd1;
                    if (r_scnt == G_MAX) begin
                        r_state <= S_OWN;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign o_grant_idx = r_grant;
    assign o_grant_oh  = NCORES'(1) << r_grant;
    assign o_hold      = (r_state != S_OWN);
    assign o_switch    = (r_state == S_SWITCH);
    assign o_state     = r_state;

`ifdef BUS_SCHED_STATS_EN
    logic [31:0] r_sw_count;
    logic [31:0] r_hold_cycles;

    // Counts are taken from the registered state, independent of the init freeze.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sw_count    <= '0;
            r_hold_cycles <= '0;
        end else begin
            if (r_state == S_SWITCH) r_sw_count <= r_sw_count + 32'd1;
            if (r_state != S_OWN) r_hold_cycles <= r_hold_cycles + 32'd1;
        end
    end

    assign o_sw_count    = r_sw_count;
    assign o_hold_cycles = r_hold_cycles;
`else
    assign o_sw_count    = '0;
    assign o_hold_cycles = '0;
`endif
endmodule

// File: tb/tb_bus_quantum_scheduler.sv
// tb_bus_quantum_scheduler: randomized bench against a window-counting reference model
module tb_bus_quantum_scheduler;
    localparam int N = 4;
    localparam int CW = 2;
    localparam int Q = 4;
    localparam int G = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          init_done = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  idle = '0;
    logic          dram_busy = 1'b0;
    logic          txn = 1'b0;
    logic [CW-1:0] grant_idx;
    logic [N-1:0]  grant_oh;
    logic          hold;
    logic          sw;
    logic [1:0]    state;
    logic [31:0]   sw_count;
    logic [31:0]   hold_cycles;

    int n_vec = 0;
    int n_err = 0;
    // Model: owner, cycles owned (saturating), position inside handover window (0 = none)
    int m_owner, m_age, m_win, m_target, m_sw, m_hc;

    bus_quantum_scheduler #(.NCORES(N), .CW(CW), .QUANTUM(Q), .GAP(G)) dut (
        .CLK(CLK), .RST(RST), .i_init_done(init_done), .i_req(req), .i_idle(idle),
        .i_dram_busy(dram_busy), .i_txn_active(txn), .o_grant_idx(grant_idx),
        .o_grant_oh(grant_oh), .o_hold(hold), .o_switch(sw), .o_state(state),
        .o_sw_count(sw_count), .o_hold_cycles(hold_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_win = 0; m_target = 0; m_sw = 0; m_hc = 0;
    endtask

    task automatic model_step();
        int c;
        int found;
        if (m_win != 0) m_hc++;
        if (m_win == 2) m_sw++;
        if (!init_done) return;
        if (m_win == 0) begin
            found = -1;
            for (int k = N - 1; k >= 1; k--) begin
                c = (m_owner + k) % N;
                if (req[c]) found = c;
            end
            if (found >= 0 && (m_age >= Q - 1 || !req[m_owner]) && idle[m_owner] && !dram_busy && !txn) begin
                m_win = 1;
                m_target = found;
            end else if (m_age < Q - 1) m_age++;
        end else if (m_win == 2 + G) begin
            m_win = 0;
            m_age = 0;
        end else begin
            m_win++;
            if (m_win == 2) m_owner = m_target;
        end
    endtask

    task automatic compare_all();
        int exp_state;
        exp_state = (m_win == 0) ? 0 : (m_win == 1) ? 1 : (m_win == 2) ? 2 : 3;
        chk("grant_idx", 32'(grant_idx), 32'(m_owner));
        chk("grant_oh", 32'(grant_oh), 32'(1) << m_owner);
        chk("hold", 32'(hold), 32'(m_win != 0));
        chk("switch", 32'(sw), 32'(m_win == 2));
        chk("state", 32'(state), 32'(exp_state));
`ifdef BUS_SCHED_STATS_EN
        chk("sw_count", sw_count, 32'(m_sw));
        chk("hold_cycles", hold_cycles, 32'(m_hc));
`else
        chk("sw_count", sw_count, 32'd0);
        chk("hold_cycles", hold_cycles, 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        req       = N'($urandom);
        idle      = N'($urandom | $urandom);
        dram_busy = ($urandom_range(0, 7) == 0);
        txn       = ($urandom_range(0, 7) == 0);
        init_done = ($urandom_range(0, 31) != 0);
    endtask

    initial begin
        int found;
        model_reset();
        #3;
        compare_all();
        @(negedge CLK);
        RST = 1'b0;
        // frozen scheduler with every core requesting
        req = '1; idle = '1;
        for (int i = 0; i < 20; i++) tick();
        chk("frozen_no_switch", 32'(m_sw), 32'd0);
        // free-running rotation among all cores
        init_done = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        // lone requester keeps the bus, then a competitor appears after saturation
        req = 4'b0001;
        for (int i = 0; i < 40; i++) tick();
        req = 4'b1010;
        for (int i = 0; i < 20; i++) tick();
        // owner blocked by not-idle, then by txn, then by dram busy
        req = '1; idle = 4'b0000;
        for (int i = 0; i < 10; i++) tick();
        idle = '1; txn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        txn = 1'b0; dram_busy = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        dram_busy = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            tick();
        end
        // asynchronous reset while settling with a nonzero owner
        req = '1; idle = '1; dram_busy = 1'b0; txn = 1'b0; init_done = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (m_win == 3 && m_owner != 0) found = 1;
        end
        chk("settle_reached", 32'(found), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 500; i++) begin
            rand_inputs();
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
